// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the baud divider.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  // Rounded clocks per oversample tick; never below one.
  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    int d;
    d = (clk_freq + (baud * os) / 2) / (baud * os);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous FIFO with first-word-fall-through head; a push into a full FIFO
// is only accepted when a pop frees a slot in the same cycle.
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, push_ok, pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;
  // Head reads as zero when empty so the output is defined out of reset.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling 8N1 receiver feeding a byte FIFO, with sticky overrun and
// framing-error flags.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rxd,
  output logic [7:0]                    rx_data,
  output logic                          rx_ready,
  input  logic                          rx_clear,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          overrun,
  output logic                          frame_err,
  input  logic                          err_clear
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVERSAMPLE);

  logic                 sync1, rxs;
  logic [TW-1:0]        tick_cnt;
  logic                 tick, restart, decide, maj;
  logic [OW-1:0]        os_cnt;
  logic [2:0]           bit_cnt;
  logic [1:0]           smp;
  logic [DATA_BITS-1:0] shreg;
  rx_state_t            state;
  logic                 push, bad_stop, empty, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxs   <= sync1;
    end
  end

  assign tick     = (tick_cnt == TW'(DIV - 1));
  assign restart  = (state == IDLE) && !rxs;
  // Decision on the third mid-bit sample; the first two are already stored.
  assign decide   = tick && (os_cnt == OW'(OVERSAMPLE / 2 + 1));
  assign maj      = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign push     = (state == STOP) && decide && maj;
  assign bad_stop = (state == STOP) && decide && !maj;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      os_cnt   <= '0;
      bit_cnt  <= '0;
      smp      <= '0;
      shreg    <= '0;
    end else begin
      tick_cnt <= (tick || restart) ? '0 : tick_cnt + 1'b1;
      if (tick) begin
        if (os_cnt == OW'(OVERSAMPLE / 2 - 1)) smp[0] <= rxs;
        if (os_cnt == OW'(OVERSAMPLE / 2))     smp[1] <= rxs;
        os_cnt <= (os_cnt == OW'(OVERSAMPLE - 1)) ? '0 : os_cnt + 1'b1;
      end
      case (state)
        IDLE: if (!rxs) begin
          state   <= START;
          os_cnt  <= '0;
          bit_cnt <= '0;
        end
        START: if (decide) state <= maj ? IDLE : DATA;
        DATA: if (decide) begin
          shreg   <= {maj, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'(DATA_BITS - 1)) state <= STOP;
        end
        // Leave at mid-stop so a back-to-back start edge is not missed.
        STOP:    if (decide) state <= maj ? IDLE : BREAK;
        BREAK:   if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (bad_stop)       frame_err <= 1'b1;
      else if (err_clear) frame_err <= 1'b0;
      if (drop)           overrun <= 1'b1;
      else if (err_clear) overrun <= 1'b0;
    end
  end

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (shreg),
    .pop       (rx_clear),
    .head      (rx_data),
    .empty     (empty),
    .drop      (drop),
    .count     (rx_count)
  );

  assign rx_ready = !empty;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Scoreboarded bench for uart_rx_buffered at a fast line rate (2 clk per tick, 32 clk per bit).
module tb_uart_rx_buffered;

  localparam int BIT = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_clear = 1'b0;
  logic       err_clear = 1'b0;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [4:0] rx_count;
  logic       overrun;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_buffered #(
    .CLK_FREQ(307200), .BAUD(9600), .OVERSAMPLE(16), .FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rxd(rxd), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_clear(rx_clear), .rx_count(rx_count), .overrun(overrun),
    .frame_err(frame_err), .err_clear(err_clear)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_bits);
    rxd = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(BIT);
    end
    rxd = stop;
    idle(BIT * stop_bits);
    rxd = 1'b1;
  endtask

  task automatic pop();
    rx_clear = 1'b1;
    idle(1);
    rx_clear = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rx_data"}, rx_data, 8'h00);
    chk({tag, "_rx_ready"}, rx_ready, 1'b0);
    chk({tag, "_rx_count"}, rx_count, 5'd0);
    chk({tag, "_overrun"}, overrun, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
  endtask

  // Monitor: every accepted pop must present the next expected byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rx_clear && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL pop_unexpected actual=0x%0h expected=none @%0t", rx_data, $time);
        end else begin
          chk("pop_data", rx_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    idle(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    idle(5);

    // Single byte with exact stop-decision latency.
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1, 1);
      begin
        repeat (310) @(posedge clk);
        @(negedge clk);
        chk("lat_before", rx_ready, 1'b0);
        @(negedge clk);
        chk("lat_after", rx_ready, 1'b1);
      end
    join
    chk("t1_data", rx_data, 8'h55);
    chk("t1_count", rx_count, 5'd1);
    pop();
    chk("t1_ready_after_pop", rx_ready, 1'b0);
    chk("t1_count_after_pop", rx_count, 5'd0);

    // Back-to-back frames.
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    send_frame(8'hA5, 1'b1, 1);
    send_frame(8'h3C, 1'b1, 1);
    idle(4);
    chk("t2_count", rx_count, 5'd2);
    chk("t2_head", rx_data, 8'hA5);
    pop();
    chk("t2_head2", rx_data, 8'h3C);
    pop();

    // Start-bit glitch of 3 ticks is rejected.
    rxd = 1'b0;
    idle(6);
    rxd = 1'b1;
    idle(60);
    chk("t3_glitch_count", rx_count, 5'd0);
    chk("t3_glitch_ready", rx_ready, 1'b0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1);
    chk("t3_count", rx_count, 5'd1);
    pop();

    // Framing error / break, then recovery and flag clear.
    send_frame(8'h00, 1'b0, 2);
    idle(BIT);
    chk("t4_frame_err", frame_err, 1'b1);
    chk("t4_count", rx_count, 5'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1);
    chk("t4_count2", rx_count, 5'd1);
    chk("t4_sticky", frame_err, 1'b1);
    pop();
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    chk("t4_cleared", frame_err, 1'b0);

    // Overrun: 17 bytes into 16 entries.
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1);
    end
    idle(4);
    chk("t5_count", rx_count, 5'd16);
    chk("t5_overrun", overrun, 1'b1);
    chk("t5_head", rx_data, 8'h00);
    for (int i = 0; i < 16; i++) pop();
    chk("t5_drained", rx_count, 5'd0);
    chk("t5_overrun_sticky", overrun, 1'b1);
    err_clear = 1'b1;
    idle(1);
    err_clear = 1'b0;
    chk("t5_overrun_clr", overrun, 1'b0);

    // Reset mid-frame with bytes queued.
    send_frame(8'h11, 1'b1, 1);
    send_frame(8'h22, 1'b1, 1);
    send_frame(8'h33, 1'b1, 1);
    chk("t6_queued", rx_count, 5'd3);
    rxd = 1'b0;
    idle(BIT * 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_reset");
    rxd = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(5);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1);
    chk("t6_data", rx_data, 8'h81);
    chk("t6_count", rx_count, 5'd1);
    pop();

    idle(5);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
